// File: rtl/clk_div_monitor_pkg.sv
// Shared definitions for clock-domain monitors: FSM encodings, error counter
// width and a saturating increment helper.
package clk_mon_defs;

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_ACQ  = 2'd1,
        S_LOCK = 2'd2
    } state_e;

    localparam int unsigned      ERR_W   = 8;
    localparam logic [ERR_W-1:0] ERR_MAX = 8'hFF;

    // Error counters hold at ERR_MAX instead of wrapping.
    function automatic logic [ERR_W-1:0] err_inc(input logic [ERR_W-1:0] e);
        return (e == ERR_MAX) ? e : e + ERR_W'(1);
    endfunction

endpackage

// File: rtl/clk_div_monitor_if.sv
// Monitored-clock input and health-status outputs of the clock-divider monitor.
interface clk_div_monitor_if #(
    parameter int unsigned CNT_W = 8
);
    import clk_mon_defs::*;

    logic             mon_in;
    logic [CNT_W-1:0] period;
    logic             period_vld;
    logic             locked;
    logic             timeout;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output mon_in,
        input  period, period_vld, locked, timeout, err_cnt
    );

    modport slave (
        input  mon_in,
        output period, period_vld, locked, timeout, err_cnt
    );

endinterface

// File: rtl/clk_div_monitor_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit, reset to 0.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures the period of a divided clock in clkin cycles and qualifies it,
// reporting lock, timeout and a saturating count of bad periods.
module clk_div_monitor #(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned EXP_PERIOD = 3,
    parameter int unsigned TOL        = 0,
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic             clkin,
    input  logic             rst,
    clk_div_monitor_if.slave mon_if
);
    import clk_mon_defs::*;

    localparam int unsigned       GOOD_W   = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  TO_THR   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W:0]    EXP_X    = (CNT_W + 1)'(EXP_PERIOD);
    localparam logic [CNT_W:0]    TOL_X    = (CNT_W + 1)'(TOL);
    localparam logic [GOOD_W-1:0] LOCK_THR = GOOD_W'(LOCK_CNT);

    logic              s2;
    logic              s3_q;
    logic              rise;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [CNT_W-1:0]  meas;
    logic [CNT_W:0]    meas_x;
    logic [CNT_W:0]    abs_diff;
    logic              good;
    logic              to_hit;

    state_e            state_q;
    logic [GOOD_W-1:0] good_cnt_q;
    logic [GOOD_W-1:0] good_cnt_inc;
    logic [CNT_W-1:0]  period_q;
    logic              period_vld_q;
    logic              locked_q;
    logic              timeout_q;
    logic [ERR_W-1:0]  err_cnt_q;

    sync_2ff u_sync (
        .clk_i (clkin),
        .rst_i (rst),
        .d_i   (mon_if.mon_in),
        .q_o   (s2)
    );

    // Edge detector on the synchronised monitored clock.
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            s3_q <= 1'b0;
        end else begin
            s3_q <= s2;
        end
    end

    assign rise = s2 & ~s3_q;

    // Period counter: restarts on every reference edge, holds at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (rise) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Compare is done one bit wider so the absolute difference never wraps.
    assign meas         = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    assign meas_x       = {1'b0, meas};
    assign abs_diff     = (meas_x >= EXP_X) ? (meas_x - EXP_X) : (EXP_X - meas_x);
    assign good         = (abs_diff <= TOL_X);
    assign to_hit       = (cnt_q == TO_THR);
    assign good_cnt_inc = good_cnt_q + GOOD_W'(1);

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            state_q      <= S_WAIT;
            good_cnt_q   <= '0;
            period_q     <= '0;
            period_vld_q <= 1'b0;
            locked_q     <= 1'b0;
            timeout_q    <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            period_vld_q <= 1'b0;
            case (state_q)
                S_WAIT: begin
                    // First edge only establishes the reference; nothing to measure yet.
                    if (rise) begin
                        state_q    <= S_ACQ;
                        good_cnt_q <= '0;
                        timeout_q  <= 1'b0;
                    end
                end
                S_ACQ: begin
                    if (rise) begin
                        period_q     <= meas;
                        period_vld_q <= 1'b1;
                        if (good) begin
                            good_cnt_q <= good_cnt_inc;
                            if (good_cnt_inc == LOCK_THR) begin
                                state_q  <= S_LOCK;
                                locked_q <= 1'b1;
                            end
                        end else begin
                            good_cnt_q <= '0;
                            err_cnt_q  <= err_inc(err_cnt_q);
                        end
                    end else if (to_hit) begin
                        state_q    <= S_WAIT;
                        timeout_q  <= 1'b1;
                        locked_q   <= 1'b0;
                        good_cnt_q <= '0;
                    end
                end
                S_LOCK: begin
                    if (rise) begin
                        period_q     <= meas;
                        period_vld_q <= 1'b1;
                        if (!good) begin
                            state_q    <= S_ACQ;
                            locked_q   <= 1'b0;
                            good_cnt_q <= '0;
                            err_cnt_q  <= err_inc(err_cnt_q);
                        end
                    end else if (to_hit) begin
                        state_q    <= S_WAIT;
                        timeout_q  <= 1'b1;
                        locked_q   <= 1'b0;
                        good_cnt_q <= '0;
                    end
                end
                default: begin
                    state_q    <= S_WAIT;
                    locked_q   <= 1'b0;
                    good_cnt_q <= '0;
                end
            endcase
        end
    end

    assign mon_if.period     = period_q;
    assign mon_if.period_vld = period_vld_q;
    assign mon_if.locked     = locked_q;
    assign mon_if.timeout    = timeout_q;
    assign mon_if.err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Scoreboard bench for clk_div_monitor: two instances (TOL=0 and TOL=1) see the
// same monitored clock; expected period reports are queued and checked on period_vld.
module tb_clk_div_monitor;
    import clk_mon_defs::*;

    localparam int TIMEOUT_CYC = 15;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    clk_div_monitor_if #(.CNT_W(8)) if0 ();
    clk_div_monitor_if #(.CNT_W(8)) if1 ();

    clk_div_monitor #(.TOL(0)) dut0 (.clkin(clk), .rst(rst), .mon_if(if0));
    clk_div_monitor #(.TOL(1)) dut1 (.clkin(clk), .rst(rst), .mon_if(if1));

    typedef struct {
        int period;
        int locked;
        int err;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int n_chk  = 0;
    int n_fail = 0;

    int m_wait[2];
    int m_lock[2];
    int m_good[2];
    int m_err[2];
    int m_tol[2] = '{0, 1};
    int last_p   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Period-level model: a rise measures the gap set by the previous issue() call.
    task automatic model_rise(input int d);
        exp_t e;
        int   diff;
        if (m_wait[d] != 0 || last_p > TIMEOUT_CYC) begin
            m_wait[d] = 0;
            m_lock[d] = 0;
            m_good[d] = 0;
        end else begin
            diff = last_p - 3;
            if (diff < 0) diff = -diff;
            if (diff <= m_tol[d]) begin
                if (m_lock[d] == 0) begin
                    m_good[d]++;
                    if (m_good[d] == 4) m_lock[d] = 1;
                end
            end else begin
                m_lock[d] = 0;
                m_good[d] = 0;
                if (m_err[d] < 255) m_err[d]++;
            end
            e.period = last_p;
            e.locked = m_lock[d];
            e.err    = m_err[d];
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_wait[d] = 1;
            m_lock[d] = 0;
            m_good[d] = 0;
            m_err[d]  = 0;
        end
    endtask

    // One mon_in period of p clkin cycles (high for one cycle); optional status check
    // on DUT0 after posedge chk_at, and of timeout after posedge chk_at-1.
    task automatic issue(input int p, input int chk_at, input int prev_to,
                         input int exp_to, input int exp_lk);
        model_rise(0);
        model_rise(1);
        last_p     = p;
        if0.mon_in = 1'b1;
        if1.mon_in = 1'b1;
        for (int c = 1; c <= p; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 1) begin
                if0.mon_in = 1'b0;
                if1.mon_in = 1'b0;
            end
            if (chk_at > 0 && c == chk_at - 1)
                chk("timeout_before", int'(if0.timeout), prev_to);
            if (chk_at > 0 && c == chk_at) begin
                chk("timeout", int'(if0.timeout), exp_to);
                chk("locked", int'(if0.locked), exp_lk);
                chk("no_period_vld", int'(if0.period_vld), 0);
            end
        end
    endtask

    // Assert reset between clkin edges and check outputs clear before the next edge.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_period", int'(if0.period), 0);
        chk("rst_period_vld", int'(if0.period_vld), 0);
        chk("rst_locked", int'(if0.locked), 0);
        chk("rst_timeout", int'(if0.timeout), 0);
        chk("rst_err_cnt", int'(if0.err_cnt), 0);
        chk("rst_err_cnt1", int'(if1.err_cnt), 0);
        chk("rst_locked1", int'(if1.locked), 0);
        chk("pending0", q0.size(), 0);
        chk("pending1", q1.size(), 0);
        q0.delete();
        q1.delete();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && if0.period_vld) begin
            chk("vld0_expected", int'(q0.size() > 0), 1);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                chk("period0", int'(if0.period), e.period);
                chk("locked0", int'(if0.locked), e.locked);
                chk("err_cnt0", int'(if0.err_cnt), e.err);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && if1.period_vld) begin
            chk("vld1_expected", int'(q1.size() > 0), 1);
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("period1", int'(if1.period), e.period);
                chk("locked1", int'(if1.locked), e.locked);
                chk("err_cnt1", int'(if1.err_cnt), e.err);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        if0.mon_in = 1'b0;
        if1.mon_in = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        do_reset();

        // Divide-by-3 clock: lock after four good periods.
        repeat (6) issue(3, 0, 0, 0, 0);

        // Stall: timeout 15 cycles after the last rise, cleared by the next rise.
        issue(20, 18, 0, 1, 0);
        issue(3, 3, 1, 0, 0);
        repeat (5) issue(3, 0, 0, 0, 0);

        // One long period breaks lock, four good periods restore it.
        issue(5, 0, 0, 0, 0);
        repeat (5) issue(3, 0, 0, 0, 0);

        // Async reset while locked; first rise afterwards reports nothing.
        chk("locked_before_rst", int'(if0.locked), 1);
        do_reset();
        issue(3, 3, 0, 0, 0);

        // Persistently wrong period: error counter saturates, never locks.
        repeat (301) issue(6, 0, 0, 0, 0);
        chk("err_sat0", int'(if0.err_cnt), 255);
        chk("err_sat_locked0", int'(if0.locked), 0);

        // Tolerance 1 on dut1: 3/4 alternation locks, a 5 is bad.
        do_reset();
        issue(3, 0, 0, 0, 0);
        issue(4, 0, 0, 0, 0);
        issue(3, 0, 0, 0, 0);
        issue(4, 0, 0, 0, 0);
        issue(3, 0, 0, 0, 0);
        issue(5, 0, 0, 0, 0);
        issue(3, 0, 0, 0, 0);
        issue(3, 0, 0, 0, 0);

        repeat (5) @(negedge clk);
        chk("drain0", q0.size(), 0);
        chk("drain1", q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
